uart_rx_mmio: RTL



---
 rtl/uart_rx_mmio.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - memory-mapped UART receiver (8N1, LSB first) with receive FIFO, status flags and level IRQ
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and enables STATUS.parity_err.
module uart_rx_mmio #(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        rx,
  output logic        irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   CNT_MAX  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  logic          rx_meta, rx_s;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          push, frame_set, par_set;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, push_ok, pop, ovr_set;
  logic          overrun, frame_err, parity_err, irq_en;

  logic          req, rd_req, clr;
  logic [1:0]    reg_sel;
  logic [31:0]   rdata_next;
  logic          unused_bits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (!rx_s) begin
            state <= S_START;
            cnt   <= CNT_HALF;
          end
        S_START:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!rx_s) begin
            state   <= S_DATA;
            cnt     <= CNT_FULL;
            bit_idx <= '0;
            par_bad <= 1'b0;
          end else state <= S_IDLE;
        S_DATA:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= CNT_FULL;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        S_PARITY:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            par_bad <= ^{shreg, rx_s};
            cnt     <= CNT_FULL;
            state   <= S_STOP;
          end
        S_STOP:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rx_s) state <= S_IDLE;
          else state <= S_WAIT_IDLE;
        S_WAIT_IDLE:
          if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stop-bit decision strobes; shreg and par_bad are stable throughout STOP.
  assign push      = (state == S_STOP) && (cnt == '0) && rx_s;
  assign frame_set = (state == S_STOP) && (cnt == '0) && !rx_s;
`ifdef UART_RX_PARITY_EN
  assign par_set   = push && par_bad;
`else
  assign par_set   = 1'b0;
`endif

  assign req     = sel & mem_valid & ~mem_ready;
  assign rd_req  = req && (mem_wstrb == 4'h0);
  assign reg_sel = mem_addr[3:2];
  assign clr     = req && (reg_sel == 2'd1) && mem_wstrb[0];

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign pop     = rd_req && (reg_sel == 2'd0) && !empty;
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_comb begin
    rdata_next = '0;
    case (reg_sel)
      2'd0:    if (!empty) rdata_next = {24'h0, fifo_mem[rd_ptr]};
      2'd1:    rdata_next = {27'h0, full, parity_err, frame_err, overrun, ~empty};
      2'd2:    rdata_next = {31'h0, irq_en};
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      irq_en     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      mem_ready <= req;
      mem_rdata <= rd_req ? rdata_next : '0;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Hardware set is OR'd in after the clear so a coincident event is never lost.
      overrun    <= (overrun    & ~(clr & mem_wdata[1])) | ovr_set;
      frame_err  <= (frame_err  & ~(clr & mem_wdata[2])) | frame_set;
      parity_err <= (parity_err & ~(clr & mem_wdata[3])) | par_set;
      if (req && (reg_sel == 2'd2) && mem_wstrb[0]) irq_en <= mem_wdata[0];
      irq <= irq_en & (~empty | overrun | frame_err | parity_err);
    end
  end

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:4], par_bad};

endmodule
